mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 50 +++++
 rtl/mem_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants and helpers for the byte-serial memory controller:
// I/O port address, transfer sizes, FSM state and transfer-source encodings.
package mem_ctrl_pkg;

  localparam logic [31:0] IO_ADDR_DEFAULT = 32'h0003_0000;

  localparam logic [5:0] SIZE_BYTE = 6'd1;
  localparam logic [5:0] SIZE_HALF = 6'd2;
  localparam logic [5:0] SIZE_WORD = 6'd4;

  localparam logic [2:0] FETCH_BYTES = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef enum logic {
    SRC_FETCH = 1'b0,
    SRC_LOAD  = 1'b1
  } src_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  nbytes;
    logic        sgn;
  } load_req_t;

  // Illegal size codes fall back to a full word.
  function automatic logic [2:0] size_bytes(input logic [5:0] size);
    case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      default:   size_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                              input logic [2:0]  nbytes,
                                              input logic        sgn);
    case (nbytes)
      3'd1:    extend_load = {{24{sgn & raw[7]}}, raw[7:0]};
      3'd2:    extend_load = {{16{sgn & raw[15]}}, raw[15:0]};
      default: extend_load = raw;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating committed stores, data loads and
// instruction fetches onto a single 8-bit synchronous RAM port.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_ADDR = IO_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_done,
  output logic [31:0] fetch_inst,
  input  logic        if_out_mem,
  input  logic [5:0]  out_mem_size,
  input  logic        out_mem_signed,
  input  logic [31:0] out_mem_addr,
  output logic        if_get_mem,
  output logic [31:0] data_mem,
  input  logic        store_req,
  input  logic [5:0]  store_size,
  input  logic [31:0] store_addr,
  input  logic [31:0] store_data,
  output logic        store_done,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  state_e      state_q, state_d;
  src_e        src_q, src_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  len_q, len_d;
  logic        sgn_q, sgn_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] buf_q, buf_d;
  load_req_t   pend_q, pend_d;

  logic        fetch_done_d, if_get_mem_d, store_done_d;
  logic [31:0] fetch_inst_d, data_mem_d;

  load_req_t   new_load, load_sel;
  logic        take_new;
  logic [31:0] xfer_addr;
  logic [31:0] rd_buf;
  logic        io_stall;

  assign new_load  = '{valid: if_out_mem, addr: out_mem_addr,
                       nbytes: size_bytes(out_mem_size), sgn: out_mem_signed};
  assign load_sel  = pend_q.valid ? pend_q : new_load;
  assign xfer_addr = addr_q + 32'(cnt_q);
  assign io_stall  = (state_q == ST_WRITE) && (xfer_addr == IO_ADDR) && io_buffer_full;

  // Byte k of a read arrives while cnt_q == k+1 (one-cycle RAM latency).
  always_comb begin
    rd_buf = buf_q;
    case (cnt_q)
      3'd1:    rd_buf[7:0]   = mem_din;
      3'd2:    rd_buf[15:8]  = mem_din;
      3'd3:    rd_buf[23:16] = mem_din;
      3'd4:    rd_buf[31:24] = mem_din;
      default: rd_buf        = buf_q;
    endcase
  end

  always_comb begin
    // NOTE: every variable is given a default first, so no path can leave one
    // unassigned and infer a latch.
    state_d      = state_q;
    src_d        = src_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    sgn_d        = sgn_q;
    addr_d       = addr_q;
    buf_d        = buf_q;
    pend_d       = pend_q;
    take_new     = 1'b0;
    fetch_done_d = 1'b0;
    if_get_mem_d = 1'b0;
    store_done_d = 1'b0;
    fetch_inst_d = fetch_inst;
    data_mem_d   = data_mem;

    case (state_q)
      ST_IDLE: begin
        // Held requests are ignored while their own done pulse is still visible,
        // since the requester has not yet had a cycle to drop them.
        if (store_req && !store_done) begin
          state_d = ST_WRITE;
          cnt_d   = '0;
          len_d   = size_bytes(store_size);
          addr_d  = store_addr;
          buf_d   = store_data;
        end else if (!clear && load_sel.valid) begin
          state_d      = ST_READ;
          src_d        = SRC_LOAD;
          cnt_d        = '0;
          len_d        = load_sel.nbytes;
          sgn_d        = load_sel.sgn;
          addr_d       = load_sel.addr;
          buf_d        = '0;
          take_new     = !pend_q.valid;
          pend_d.valid = 1'b0;
        end else if (!clear && fetch_req && !fetch_done) begin
          state_d = ST_READ;
          src_d   = SRC_FETCH;
          cnt_d   = '0;
          len_d   = FETCH_BYTES;
          sgn_d   = 1'b0;
          addr_d  = fetch_addr;
          buf_d   = '0;
        end
      end

      ST_READ: begin
        if (clear) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          buf_d = rd_buf;
          if (cnt_q == len_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (src_q == SRC_FETCH) begin
              fetch_done_d = 1'b1;
              fetch_inst_d = rd_buf;
            end else begin
              if_get_mem_d = 1'b1;
              data_mem_d   = extend_load(rd_buf, len_q, sgn_q);
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      ST_WRITE: begin
        if (!io_stall) begin
          if (cnt_q == len_q - 3'd1) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            store_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (clear) begin
      pend_d = '0;
    end else if (if_out_mem && !take_new) begin
      pend_d = new_load;
    end
  end

  // RAM port is decoded straight from the state so an I/O stall blanks it in
  // the same cycle the buffer reports full.
  always_comb begin
    mem_wr   = 1'b0;
    mem_a    = '0;
    mem_dout = '0;
    if (state_q == ST_READ && cnt_q < len_q) begin
      mem_a = xfer_addr;
    end else if (state_q == ST_WRITE && !io_stall) begin
      mem_wr   = 1'b1;
      mem_a    = xfer_addr;
      mem_dout = buf_q[{cnt_q[1:0], 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      src_q      <= SRC_FETCH;
      cnt_q      <= '0;
      len_q      <= '0;
      sgn_q      <= 1'b0;
      addr_q     <= '0;
      buf_q      <= '0;
      pend_q     <= '0;
      fetch_done <= 1'b0;
      if_get_mem <= 1'b0;
      store_done <= 1'b0;
      fetch_inst <= '0;
      data_mem   <= '0;
    end else if (rdy) begin
      // NOTE: non-blocking assignments keep every register updating from the
      // pre-edge values, independent of statement order.
      state_q    <= state_d;
      src_q      <= src_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      sgn_q      <= sgn_d;
      addr_q     <= addr_d;
      buf_q      <= buf_d;
      pend_q     <= pend_d;
      fetch_done <= fetch_done_d;
      if_get_mem <= if_get_mem_d;
      store_done <= store_done_d;
      fetch_inst <= fetch_inst_d;
      data_mem   <= data_mem_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: RAM model, scoreboard queues for fetch/load
// results and write bytes, plus directed checks for priority, I/O stall and clear.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam logic [31:0] IO_A = 32'h0003_0000;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst, rdy, clear;
  logic        fetch_req, fetch_done;
  logic [31:0] fetch_addr, fetch_inst;
  logic        if_out_mem, out_mem_signed, if_get_mem;
  logic [5:0]  out_mem_size;
  logic [31:0] out_mem_addr, data_mem;
  logic        store_req, store_done;
  logic [5:0]  store_size;
  logic [31:0] store_addr, store_data;
  logic        io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] fq[$];
  logic [31:0] lq[$];
  wr_t         wq[$];
  logic [7:0]  ram[logic [31:0]];

  mem_ctrl #(.IO_ADDR(IO_A)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_done(fetch_done), .fetch_inst(fetch_inst),
    .if_out_mem(if_out_mem), .out_mem_size(out_mem_size),
    .out_mem_signed(out_mem_signed), .out_mem_addr(out_mem_addr),
    .if_get_mem(if_get_mem), .data_mem(data_mem),
    .store_req(store_req), .store_size(store_size), .store_addr(store_addr),
    .store_data(store_data), .store_done(store_done),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  // Synchronous RAM: one-cycle read latency, write on the same edge.
  always @(posedge clk) begin
    mem_din <= ram_rd(mem_a);
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboards whenever the DUT produces a result.
  logic prev_fd = 1'b0, prev_gm = 1'b0, prev_sd = 1'b0;
  always @(negedge clk) begin
    wr_t e;
    if (fetch_done || if_get_mem || store_done)
      check("done_onehot", 32'(fetch_done) + 32'(if_get_mem) + 32'(store_done), 32'd1);
    if (fetch_done) begin
      check("fetch_done_width", 32'(prev_fd), 32'd0);
      check("fetch_expected", 32'(fq.size() != 0), 32'd1);
      if (fq.size() != 0) check("fetch_inst", fetch_inst, fq.pop_front());
    end
    if (if_get_mem) begin
      check("load_done_width", 32'(prev_gm), 32'd0);
      check("load_expected", 32'(lq.size() != 0), 32'd1);
      if (lq.size() != 0) check("data_mem", data_mem, lq.pop_front());
    end
    if (store_done) check("store_done_width", 32'(prev_sd), 32'd0);
    if (mem_wr) begin
      check("wr_expected", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        e = wq.pop_front();
        check("wr_addr", mem_a, e.addr);
        check("wr_data", 32'(mem_dout), 32'(e.data));
      end
    end
    prev_fd = fetch_done;
    prev_gm = if_get_mem;
    prev_sd = store_done;
  end

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp, output int lat);
    int  t0;
    bit  seen;
    fq.push_back(exp);
    fetch_addr = a;
    fetch_req  = 1'b1;
    t0   = cyc;
    seen = 1'b0;
    lat  = -1;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (fetch_done) begin
        seen = 1'b1;
        lat  = cyc - t0 - 1;
      end
    end
    fetch_req = 1'b0;
    check("fetch_timeout", 32'(seen), 32'd1);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [5:0] size,
                         input logic sgn, input logic [31:0] exp);
    bit seen;
    lq.push_back(exp);
    out_mem_addr   = a;
    out_mem_size   = size;
    out_mem_signed = sgn;
    if_out_mem     = 1'b1;
    @(posedge clk);
    #1 if_out_mem = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (if_get_mem) seen = 1'b1;
    end
    check("load_timeout", 32'(seen), 32'd1);
  endtask

  task automatic push_store(input logic [31:0] a, input logic [5:0] size, input logic [31:0] d);
    for (int k = 0; k < int'(size); k++)
      wq.push_back('{addr: a + 32'(k), data: d[8*k +: 8]});
    store_addr = a;
    store_size = size;
    store_data = d;
    store_req  = 1'b1;
  endtask

  task automatic wait_store();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (store_done) seen = 1'b1;
    end
    store_req = 1'b0;
    check("store_timeout", 32'(seen), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int order[$];
    int nfd;

    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h00;
    ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h93;
    ram[32'h0080] = 8'h80;
    ram[32'h0090] = 8'h34; ram[32'h0091] = 8'hF2;

    rst = 1'b0; rdy = 1'b1; clear = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h1000;
    if_out_mem = 1'b0; out_mem_size = SIZE_WORD; out_mem_signed = 1'b0; out_mem_addr = '0;
    store_req = 1'b0; store_size = SIZE_WORD; store_addr = '0; store_data = '0;
    io_buffer_full = 1'b0;

    // Reset held with a fetch pending: nothing may move.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fetch_done", 32'(fetch_done), 32'd0);
    check("rst_if_get_mem", 32'(if_get_mem), 32'd0);
    check("rst_store_done", 32'(store_done), 32'd0);
    check("rst_mem_wr",     32'(mem_wr), 32'd0);
    check("rst_mem_a",      mem_a, 32'd0);
    check("rst_mem_dout",   32'(mem_dout), 32'd0);
    check("rst_fetch_inst", fetch_inst, 32'd0);
    check("rst_data_mem",   data_mem, 32'd0);
    fetch_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Fetch latency and little-endian assembly.
    do_fetch(32'h1000, 32'h9300_0013, lat);
    check("fetch_latency", 32'(lat), 32'd5);
    repeat (2) @(posedge clk);
    #1;

    // Sign/zero extension at byte and half sizes.
    do_load(32'h0080, SIZE_BYTE, 1'b1, 32'hFFFF_FF80);
    do_load(32'h0080, SIZE_BYTE, 1'b0, 32'h0000_0080);
    do_load(32'h0090, SIZE_HALF, 1'b1, 32'hFFFF_F234);
    do_load(32'h0090, SIZE_HALF, 1'b0, 32'h0000_F234);

    // Word store then read-back; half store writes only its two low bytes.
    push_store(32'h0200, SIZE_WORD, 32'hDEAD_BEEF);
    wait_store();
    do_load(32'h0200, SIZE_WORD, 1'b0, 32'hDEAD_BEEF);
    push_store(32'h0300, SIZE_HALF, 32'hA5A5_1234);
    wait_store();
    do_load(32'h0300, SIZE_WORD, 1'b0, 32'h0000_1234);
    repeat (2) @(posedge clk);
    #1;

    // Simultaneous store, load pulse and fetch: served store, load, fetch.
    push_store(32'h0400, SIZE_BYTE, 32'h0000_0055);
    lq.push_back(32'h9300_0013);
    fq.push_back(32'hDEAD_BEEF);
    out_mem_addr = 32'h1000; out_mem_size = SIZE_WORD; out_mem_signed = 1'b0;
    if_out_mem = 1'b1;
    fetch_addr = 32'h0200;
    fetch_req  = 1'b1;
    @(posedge clk);
    #1 if_out_mem = 1'b0;
    for (int i = 0; i < 200 && order.size() < 3; i++) begin
      @(negedge clk);
      if (store_done) begin order.push_back(0); store_req = 1'b0; end
      if (if_get_mem) order.push_back(1);
      if (fetch_done) begin order.push_back(2); fetch_req = 1'b0; end
    end
    store_req = 1'b0;
    fetch_req = 1'b0;
    check("prio_count", 32'(order.size()), 32'd3);
    for (int i = 0; i < order.size(); i++) check("prio_order", 32'(order[i]), 32'(i));
    repeat (2) @(posedge clk);
    #1;

    // I/O store held off for exactly three full-buffer cycles.
    io_buffer_full = 1'b1;
    push_store(IO_A, SIZE_BYTE, 32'h0000_0041);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("io_stall_wr", 32'(mem_wr), 32'd0);
      check("io_stall_a", mem_a, 32'd0);
    end
    @(posedge clk);
    #1 io_buffer_full = 1'b0;
    @(negedge clk);
    check("io_write_now", 32'(mem_wr), 32'd1);
    wait_store();
    check("io_ram", 32'(ram_rd(IO_A)), 32'h41);
    repeat (2) @(posedge clk);
    #1;

    // Clear mid-fetch: no done pulse, idle the cycle after clear.
    fetch_addr = 32'h1000;
    fetch_req  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear     = 1'b1;
    fetch_req = 1'b0;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    check("clear_idle_a", mem_a, 32'd0);
    check("clear_idle_wr", 32'(mem_wr), 32'd0);
    nfd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fetch_done) nfd++;
    end
    check("clear_no_done", 32'(nfd), 32'd0);
    do_fetch(32'h1000, 32'h9300_0013, lat);
    check("post_clear_latency", 32'(lat), 32'd5);

    repeat (3) @(posedge clk);
    check("fq_drained", 32'(fq.size()), 32'd0);
    check("lq_drained", 32'(lq.size()), 32'd0);
    check("wq_drained", 32'(wq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
